// File: rtl/gray_pkg.sv
// gray_pkg: pixel type and scheduler states shared by the grayscale batch scheduler
package gray_pkg;
    typedef logic [7:0] pix_t;
    typedef enum logic [1:0] {FILL, WAIT, DRAIN} state_t;
endpackage

// File: rtl/gray_lane_buffer.sv
// gray_lane_buffer: SIZE-entry register file with indexed write, parallel load and clear
module gray_lane_buffer #(
    parameter int SIZE = 100,
    parameter int W = 8,
    parameter int IW = $clog2(SIZE + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              we,
    input  logic [IW-1:0]     widx,
    input  logic [W-1:0]      wdata,
    input  logic              ld,
    input  logic [SIZE*W-1:0] ld_data,
    output logic [SIZE*W-1:0] q
);
    always_ff @(posedge clk)
        if (rst || clr) q <= '0;
        else if (ld) q <= ld_data;
        else if (we) for (int i = 0; i < SIZE; i++) if (widx == IW'(i)) q[i*W +: W] <= wdata;
endmodule

// File: rtl/grayscale_batch_scheduler.sv
// grayscale_batch_scheduler: batches a serial RGB stream into the parallel gray array and
// replays the gray results serially in arrival order with frame markers
module grayscale_batch_scheduler import gray_pkg::*; #(
    parameter int SIZE = 100,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [7:0]        R_in,
    input  logic [7:0]        G_in,
    input  logic [7:0]        B_in,
    output logic [8*SIZE-1:0] R_arr_out,
    output logic [8*SIZE-1:0] G_arr_out,
    output logic [8*SIZE-1:0] B_arr_out,
    input  logic [8*SIZE-1:0] gray_arr_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [7:0]        gray_out,
    output logic              busy
);
    localparam int IW = $clog2(SIZE + 1);
    localparam int LW = $clog2(LATENCY + 1);
    state_t state, state_n;
    logic [IW-1:0] lane_cnt, lane_n, rd_idx, rd_n, batch_len, len_n;
    logic [LW-1:0] lat_cnt, lat_n;
    logic frame_last, fl_n, wr, cap, clr;
    logic [24*SIZE-1:0] rgb_q;
    logic [8*SIZE-1:0] gbuf;
    pix_t gsel;
    // the RGB store is cleared at the end of every batch so unused lanes read 0
    gray_lane_buffer #(.SIZE(SIZE), .W(24), .IW(IW)) u_rgb (
        .clk(clk), .rst(rst), .clr(clr), .we(wr), .widx(lane_cnt), .wdata({R_in, G_in, B_in}),
        .ld(1'b0), .ld_data('0), .q(rgb_q)
    );
    gray_lane_buffer #(.SIZE(SIZE), .W(8), .IW(IW)) u_gray (
        .clk(clk), .rst(rst), .clr(1'b0), .we(1'b0), .widx('0), .wdata('0),
        .ld(cap), .ld_data(gray_arr_in), .q(gbuf)
    );
    for (genvar i = 0; i < SIZE; i++) begin : g_lane
        assign R_arr_out[i*8 +: 8] = rgb_q[i*24+16 +: 8];
        assign G_arr_out[i*8 +: 8] = rgb_q[i*24+8 +: 8];
        assign B_arr_out[i*8 +: 8] = rgb_q[i*24 +: 8];
    end
    always_comb begin
        gsel = '0;
        for (int i = 0; i < SIZE; i++) if (rd_idx == IW'(i)) gsel = gbuf[i*8 +: 8];
    end
    assign in_ready = state == FILL;
    assign out_valid = state == DRAIN;
    assign gray_out = out_valid ? gsel : '0;
    assign out_last = out_valid && frame_last && rd_idx == batch_len - IW'(1);
    assign busy = !(state == FILL && lane_cnt == '0);
    always_ff @(posedge clk)
        if (rst) begin
            state <= FILL;
            lane_cnt <= '0;
            rd_idx <= '0;
            batch_len <= '0;
            lat_cnt <= '0;
            frame_last <= 1'b0;
        end else begin
            state <= state_n;
            lane_cnt <= lane_n;
            rd_idx <= rd_n;
            batch_len <= len_n;
            lat_cnt <= lat_n;
            frame_last <= fl_n;
        end
    always_comb begin
        state_n = state;
        lane_n = lane_cnt;
        rd_n = rd_idx;
        len_n = batch_len;
        lat_n = lat_cnt;
        fl_n = frame_last;
        wr = 1'b0;
        cap = 1'b0;
        clr = 1'b0;
        case (state)
            FILL: if (in_valid) begin
                wr = 1'b1;
                lane_n = lane_cnt + IW'(1);
                if (lane_cnt == IW'(SIZE - 1) || in_last) begin
                    state_n = WAIT;
                    len_n = lane_cnt + IW'(1);
                    fl_n = in_last;
                    lat_n = '0;
                end
            end
            WAIT: begin
                lat_n = lat_cnt + LW'(1);
                if (lat_cnt == LW'(LATENCY - 1)) begin
                    cap = 1'b1;
                    rd_n = '0;
                    state_n = DRAIN;
                end
            end
            DRAIN: if (out_ready) begin
                rd_n = rd_idx + IW'(1);
                if (rd_idx == batch_len - IW'(1)) begin
                    state_n = FILL;
                    lane_n = '0;
                    clr = 1'b1;
                end
            end
            default: state_n = FILL;
        endcase
    end
endmodule

// File: tb/tb_grayscale_batch_scheduler.sv
// tb_grayscale_batch_scheduler: directed vector table plus hand-written corner sequences,
// with the gray array modelled as a pipelined (R+G+B)/3 per lane
module tb_grayscale_batch_scheduler;
    localparam int SIZE = 4;
    localparam int LATENCY = 2;
    logic clk = 0, rst = 1, in_valid = 0, in_last = 0, out_ready = 1;
    logic in_ready, out_valid, out_last, busy;
    logic [7:0] R_in = 0, G_in = 0, B_in = 0, gray_out;
    logic [8*SIZE-1:0] R_arr_out, G_arr_out, B_arr_out, gray_arr_in;
    typedef struct {
        logic [7:0] r, g, b;
        logic last;
        logic [7:0] gray;
        logic glast;
    } vec_t;
    vec_t v [0:31];
    int nv = 0;
    int acc [0:31], fvc [0:31], tc [0:31];
    int cyc = 0, errors = 0, checks = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    grayscale_batch_scheduler #(.SIZE(SIZE), .LATENCY(LATENCY)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .R_in(R_in), .G_in(G_in), .B_in(B_in), .R_arr_out(R_arr_out), .G_arr_out(G_arr_out),
        .B_arr_out(B_arr_out), .gray_arr_in(gray_arr_in), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .gray_out(gray_out), .busy(busy)
    );
    // results appear LATENCY cycles after the inputs change, counting the cycle they change in
    always @(posedge clk)
        for (int i = 0; i < SIZE; i++)
            gray_arr_in[i*8 +: 8] <= 8'((int'(R_arr_out[i*8 +: 8]) + int'(G_arr_out[i*8 +: 8]) + int'(B_arr_out[i*8 +: 8])) / 3);
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected completion", name);
    endtask
    function automatic void add(input int r, g, b, input logic last, input int gray, input logic glast);
        v[nv] = '{8'(r), 8'(g), 8'(b), last, 8'(gray), glast};
        nv++;
    endfunction
    task automatic drive(input int lo, input int hi);
        int ln = 0;
        logic [23:0] bt [SIZE];
        for (int k = lo; k < hi; k++) begin
            int n = 0;
            R_in = v[k].r;
            G_in = v[k].g;
            B_in = v[k].b;
            in_last = v[k].last;
            in_valid = 1;
            while (!in_ready && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (n == 200) timeout($sformatf("accept[%0d]", k));
            acc[k] = cyc;
            bt[ln] = {v[k].r, v[k].g, v[k].b};
            ln++;
            @(negedge clk);
            check($sformatf("busy_after_accept[%0d]", k), busy, 1);
            if (v[k].last || ln == SIZE) begin
                for (int i = 0; i < SIZE; i++)
                    check($sformatf("lane%0d_at[%0d]", i, k),
                          {R_arr_out[i*8 +: 8], G_arr_out[i*8 +: 8], B_arr_out[i*8 +: 8]},
                          i < ln ? bt[i] : 24'h0);
                ln = 0;
            end
        end
        in_valid = 0;
        in_last = 0;
    endtask
    task automatic collect(input int lo, input int hi, input logic stall);
        int idx = lo, t = 0, pc = 0;
        logic held = 0, seen = 0, hl = 0;
        logic [7:0] hg = 0;
        logic [3:0] pat = 4'b1001;
        while (idx < hi && t < 400) begin
            @(negedge clk);
            t++;
            out_ready = (stall && out_valid) ? pat[pc % 4] : 1'b1;
            if (stall && out_valid) pc++;
            if (held) begin
                check("stall_valid", out_valid, 1);
                check("stall_gray", gray_out, hg);
                check("stall_last", out_last, hl);
            end
            if (out_valid) begin
                check("in_ready_in_drain", in_ready, 0);
                if (!seen) fvc[idx] = cyc;
                seen = 1;
                if (out_ready) begin
                    check($sformatf("gray[%0d]", idx), gray_out, v[idx].gray);
                    check($sformatf("last[%0d]", idx), out_last, v[idx].glast);
                    tc[idx] = cyc;
                    idx++;
                    seen = 0;
                end
            end
            held = out_valid && !out_ready;
            hg = gray_out;
            hl = out_last;
        end
        out_ready = 1;
        if (idx < hi) timeout($sformatf("collect[%0d]", idx));
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end
    initial begin
        add(10, 10, 10, 0, 10, 0); add(20, 20, 20, 0, 20, 0);
        add(30, 30, 30, 0, 30, 0); add(40, 40, 40, 1, 40, 1);
        add(30, 60, 90, 0, 60, 0); add(255, 255, 255, 0, 255, 0);
        add(0, 0, 3, 0, 1, 0);     add(100, 50, 0, 0, 50, 0);
        add(7, 8, 9, 0, 8, 0);     add(200, 100, 0, 1, 100, 1);
        add(9, 3, 0, 1, 4, 1);
        add(1, 2, 3, 0, 2, 0);     add(50, 50, 51, 0, 50, 0);
        add(90, 0, 0, 0, 30, 0);   add(3, 3, 3, 1, 3, 1);
        add(10, 10, 10, 0, 10, 0); add(40, 0, 2, 0, 14, 0);
        add(5, 5, 5, 0, 5, 0);     add(60, 60, 60, 0, 60, 0);
        add(99, 0, 0, 1, 33, 1);
        add(6, 6, 6, 0, 6, 0);     add(7, 7, 7, 0, 7, 0);
        add(8, 8, 8, 0, 8, 0);     add(9, 9, 9, 1, 9, 1);
        add(120, 120, 123, 1, 121, 1);
        repeat (3) @(negedge clk);
        rst = 0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_gray_out", gray_out, 0);
        check("rst_busy", busy, 0);
        check("rst_R_arr", R_arr_out, 0);
        check("rst_G_arr", G_arr_out, 0);
        check("rst_B_arr", B_arr_out, 0);
        fork drive(0, 4); collect(0, 4, 0); join
        check("t1_latency", fvc[0] - acc[3], LATENCY + 1);
        fork drive(4, 10); collect(4, 10, 0); join
        check("t2_latency", fvc[8] - acc[9], LATENCY + 1);
        fork drive(10, 11); collect(10, 11, 0); join
        check("t3_latency", fvc[10] - acc[10], LATENCY + 1);
        @(negedge clk);
        check("t3_valid_after", out_valid, 0);
        check("t3_busy_after", busy, 0);
        check("t3_in_ready_after", in_ready, 1);
        fork drive(11, 15); collect(11, 15, 1); join
        fork drive(15, 20); collect(15, 20, 0); join
        check("t5_held_accept", acc[19], tc[18] + 1);
        fork drive(20, 24); collect(20, 22, 0); join
        @(negedge clk);
        check("t6_pre_rst_valid", out_valid, 1);
        check("t6_pre_rst_gray", gray_out, v[22].gray);
        rst = 1;
        out_ready = 0;
        @(negedge clk);
        rst = 0;
        out_ready = 1;
        check("t6_rst_out_valid", out_valid, 0);
        check("t6_rst_in_ready", in_ready, 1);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_gray_out", gray_out, 0);
        check("t6_rst_out_last", out_last, 0);
        check("t6_rst_R_arr", R_arr_out, 0);
        fork drive(24, 25); collect(24, 25, 0); join
        @(negedge clk);
        check("t6_valid_after", out_valid, 0);
        check("t6_busy_after", busy, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
